// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types for the instruction fetch unit and its prefetch FIFO.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT_ERR
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry prefetch buffer. Flush wins over push and pop in the same cycle.
// The head is read straight from storage, so data pushed in cycle N is visible in N+1.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            pop_eff;

  assign pop_eff = pop && (count_q != '0);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Entry storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)    wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_eff) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop_eff)      count_q <= count_q + CntW'(1);
      else if (!push && pop_eff) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction prefetcher. Issues word fetches while the FIFO plus
// in-flight requests leave room, buffers responses for decode and discards stale responses
// after a redirect. Optional macro FETCH_BUS_ERR_EN carries bus errors to decode and halts
// fetching after an erroneous entry until the next redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fetch_err_o
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned SumW = CntW + 1;

  fetch_state_e    state_q, state_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [31:0]     rsp_addr_q, rsp_addr_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic [CntW-1:0] fifo_count;
  logic            req, grant, rsp, push, pop, err_in;
  fetch_entry_t    push_data, head;

`ifdef FETCH_BUS_ERR_EN
  assign err_in      = instr_err_i;
  assign fetch_err_o = head.err;
`else
  logic unused_err;
  assign err_in      = 1'b0;
  assign fetch_err_o = 1'b0;
  assign unused_err  = instr_err_i ^ head.err;
`endif

  // A response only counts while something is in flight.
  assign rsp   = instr_rvalid_i && (outstanding_q != '0);
  // Credit: every in-flight request already owns a FIFO slot, so the FIFO cannot overflow.
  assign req   = fetch_en_i && !redirect_i && (state_q == RUN) &&
                 ((SumW'(fifo_count) + SumW'(outstanding_q)) < SumW'(DEPTH));
  assign grant = req && instr_gnt_i;
  assign push  = rsp && (discard_q == '0) && !redirect_i;
  assign pop   = instr_valid_o && instr_ready_i;

  assign push_data = '{instr: instr_rdata_i, pc: rsp_addr_q, err: err_in};

  assign instr_req_o   = req;
  assign instr_addr_o  = fetch_addr_q;
  assign instr_valid_o = (fifo_count != '0);
  assign instr_o       = head.instr;
  assign pc_o          = head.pc;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (redirect_i),
    .head     (head),
    .count    (fifo_count)
  );

  // Address and credit bookkeeping; redirect overrides grant, push and discard decrement.
  always_comb begin
    fetch_addr_d  = fetch_addr_q;
    rsp_addr_d    = rsp_addr_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (grant && !rsp)      outstanding_d = outstanding_q + CntW'(1);
    else if (!grant && rsp) outstanding_d = outstanding_q - CntW'(1);

    if (redirect_i) begin
      fetch_addr_d = word_align(redirect_pc_i);
      rsp_addr_d   = word_align(redirect_pc_i);
      // Everything still in flight after this cycle is stale.
      discard_d    = outstanding_q - CntW'(rsp);
    end else begin
      if (grant) fetch_addr_d = fetch_addr_q + 32'd4;
      if (push)  rsp_addr_d   = rsp_addr_q + 32'd4;
      if (rsp && (discard_q != '0)) discard_d = discard_q - CntW'(1);
    end
  end

  // Fetch state machine next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (fetch_en_i) state_d = RUN;
      RUN:      if (push && err_in) state_d = HALT_ERR;
      HALT_ERR: if (redirect_i) state_d = RUN;
      default:  state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      fetch_addr_q  <= BOOT_ADDR;
      rsp_addr_q    <= BOOT_ADDR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      rsp_addr_q    <= rsp_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit. A bus model returns in-order responses
// at least one cycle after grant; a queue-based model of the decode-side instruction stream
// predicts request, address and head outputs every cycle.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned DEPTH     = 2;
  localparam logic [31:0] BOOT_ADDR = 32'h0000_0000;
`ifdef FETCH_BUS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        fetch_en_i = 1'b0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_err_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        fetch_err_o;

  fetch_unit #(
    .DEPTH    (DEPTH),
    .BOOT_ADDR(BOOT_ADDR)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .fetch_en_i    (fetch_en_i),
    .instr_req_o   (instr_req_o),
    .instr_addr_o  (instr_addr_o),
    .instr_gnt_i   (instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i (instr_rdata_i),
    .instr_err_i   (instr_err_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .fetch_err_o   (fetch_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned cyc;
  } bus_req_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } model_ent_t;

  bus_req_t    bus_q[$];
  model_ent_t  fifo_q[$];
  logic [31:0] grant_log[$];
  int unsigned epoch, cyc;
  logic [31:0] exp_addr;
  bit          started, halted;
  int unsigned en_pct, gnt_pct, rv_pct, rdy_pct, redir_pct, err_pct;
  bit          force_red;
  logic [31:0] force_pc, err_addr;
  int unsigned pop_seen;
  logic [31:0] pop_pc;
  logic        pop_err;
  logic        last_valid;
  int          n_checks, n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit roll(input int unsigned pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h required 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_knobs(input int unsigned en, input int unsigned gnt, input int unsigned rv,
                           input int unsigned rdy, input int unsigned red, input int unsigned err);
    en_pct = en; gnt_pct = gnt; rv_pct = rv; rdy_pct = rdy; redir_pct = red; err_pct = err;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    fetch_en_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_err_i = 1'b0;
    redirect_i = 1'b0; instr_ready_i = 1'b0;
    #1;
    check_eq("rst_req", instr_req_o, 1'b0);
    check_eq("rst_addr", instr_addr_o, BOOT_ADDR);
    check_eq("rst_valid", instr_valid_o, 1'b0);
    check_eq("rst_instr", instr_o, 32'h0);
    check_eq("rst_pc", pc_o, 32'h0);
    check_eq("rst_err", fetch_err_o, 1'b0);
    // The bus is reset together with the core: in-flight responses vanish.
    bus_q.delete();
    fifo_q.delete();
    started  = 1'b0;
    halted   = 1'b0;
    epoch++;
    exp_addr = BOOT_ADDR;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check after settling, update model at posedge.
  task automatic step();
    bit         exp_req, exp_valid, do_grant, do_rsp, do_pop, do_red;
    logic       rsp_err;
    logic [31:0] red_pc;
    model_ent_t ent;
    bus_req_t   br;
    @(negedge clk);
    fetch_en_i     = roll(en_pct);
    instr_gnt_i    = roll(gnt_pct);
    instr_ready_i  = roll(rdy_pct);
    redirect_i     = force_red || roll(redir_pct);
    redirect_pc_i  = force_red ? force_pc : $urandom;
    force_red      = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = $urandom;
    instr_err_i    = roll(err_pct);
    if (bus_q.size() > 0 && bus_q[0].cyc < cyc && roll(rv_pct)) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mem_word(bus_q[0].addr);
      instr_err_i    = (bus_q[0].addr == err_addr) || roll(err_pct);
    end
    #1;
    exp_valid = fifo_q.size() > 0;
    exp_req   = fetch_en_i && !redirect_i && started && !halted &&
                (fifo_q.size() + bus_q.size() < DEPTH);
    check_eq("req", instr_req_o, exp_req);
    if (exp_req) check_eq("addr", instr_addr_o, exp_addr);
    check_eq("valid", instr_valid_o, exp_valid);
    if (exp_valid) begin
      check_eq("pc", pc_o, fifo_q[0].addr);
      check_eq("instr", instr_o, fifo_q[0].data);
      check_eq("ferr", fetch_err_o, fifo_q[0].err);
    end
    last_valid = instr_valid_o;
    if (instr_valid_o && instr_ready_i) begin
      pop_seen++;
      pop_pc  = pc_o;
      pop_err = fetch_err_o;
    end
    do_grant = exp_req && instr_gnt_i;
    do_rsp   = instr_rvalid_i;
    do_pop   = exp_valid && instr_ready_i;
    do_red   = redirect_i;
    rsp_err  = instr_err_i;
    red_pc   = redirect_pc_i;
    if (do_grant) grant_log.push_back(exp_addr);
    @(posedge clk);
    if (do_pop && !do_red) void'(fifo_q.pop_front());
    if (do_rsp) begin
      br = bus_q.pop_front();
      if (!do_red && br.epoch == epoch) begin
        ent.addr = br.addr;
        ent.data = mem_word(br.addr);
        ent.err  = ERR_EN && rsp_err;
        fifo_q.push_back(ent);
        if (ent.err) halted = 1'b1;
      end
    end
    if (do_grant) begin
      bus_q.push_back('{exp_addr, epoch, cyc});
      exp_addr = exp_addr + 32'd4;
    end
    if (do_red) begin
      fifo_q.delete();
      epoch++;
      exp_addr = {red_pc[31:2], 2'b00};
      halted   = 1'b0;
    end
    if (fetch_en_i) started = 1'b1;
    cyc++;
  endtask

  initial begin
    int          first_valid;
    int unsigned g0, p0;
    bit          found;
    n_checks = 0; n_fail = 0; cyc = 0; epoch = 0; pop_seen = 0;
    force_red = 1'b0; force_pc = '0; err_addr = 32'hFFFF_FFFF;
    pop_pc = '0; pop_err = 1'b0; last_valid = 1'b0;
    set_knobs(100, 100, 100, 100, 0, 0);
    do_reset();

    // Boot stream: grants at 0x0, 0x4, 0x8; first instruction valid three cycles in.
    grant_log.delete();
    first_valid = -1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (last_valid && first_valid < 0) first_valid = k;
    end
    check_eq("boot_first_valid", first_valid, 3);
    check_eq("boot_grant_count_ge3", grant_log.size() >= 3, 1'b1);
    if (grant_log.size() >= 3) begin
      check_eq("boot_addr0", grant_log[0], 32'h0);
      check_eq("boot_addr1", grant_log[1], 32'h4);
      check_eq("boot_addr2", grant_log[2], 32'h8);
    end

    // Decode stalled for 10 cycles: credit caps issue, request drops.
    set_knobs(100, 100, 100, 0, 0, 0);
    g0 = grant_log.size();
    repeat (10) step();
    #1;
    check_eq("stall_grants_le_depth", (grant_log.size() - g0) <= DEPTH, 1'b1);
    check_eq("stall_req_low", instr_req_o, 1'b0);
    set_knobs(100, 100, 100, 100, 0, 0);
    repeat (6) step();

    // Redirect with two outstanding requests: stale responses dropped, stream restarts.
    set_knobs(100, 0, 100, 100, 0, 0);
    repeat (6) step();
    set_knobs(100, 100, 0, 100, 0, 0);
    repeat (3) step();
    force_red = 1'b1;
    force_pc  = 32'h100;
    p0 = pop_seen;
    step();
    set_knobs(100, 100, 100, 100, 0, 0);
    for (int k = 0; k < 15 && pop_seen == p0; k++) step();
    check_eq("redir_pop_seen", pop_seen != p0, 1'b1);
    check_eq("redir_first_pc", pop_pc, 32'h100);

    // Unaligned redirect target is word aligned.
    force_red = 1'b1;
    force_pc  = 32'h203;
    step();
    #1;
    check_eq("redir_align", instr_addr_o, 32'h200);
    repeat (4) step();

    // Redirect coinciding with a response and a pop empties the FIFO.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (fifo_q.size() > 0 && bus_q.size() > 0) found = 1'b1;
    end
    check_eq("coinc_setup", found, 1'b1);
    force_red = 1'b1;
    force_pc  = 32'h300;
    step();
    #1;
    check_eq("coinc_flush", instr_valid_o, 1'b0);
    repeat (8) step();

    if (ERR_EN) begin
      // Bus error at 0x8 reaches decode flagged and halts fetching until a redirect.
      do_reset();
      err_addr = 32'h8;
      set_knobs(100, 100, 100, 100, 0, 0);
      p0 = 0;
      for (int k = 0; k < 15 && !(pop_err && pop_seen != p0); k++) begin
        if (k == 0) p0 = pop_seen;
        step();
      end
      check_eq("err_flag", pop_err, 1'b1);
      check_eq("err_pc", pop_pc, 32'h8);
      repeat (4) step();
      #1;
      check_eq("err_halt_req", instr_req_o, 1'b0);
      err_addr  = 32'hFFFF_FFFF;
      force_red = 1'b1;
      force_pc  = 32'h40;
      repeat (6) step();
    end

    // Randomized traffic with periodic mid-transaction resets.
    for (int b = 0; b < 20; b++) begin
      if (b % 5 == 4) do_reset();
      set_knobs($urandom_range(100, 60), $urandom_range(100, 20), $urandom_range(100, 20),
                $urandom_range(100, 20), $urandom_range(8, 1),
                ERR_EN ? $urandom_range(5, 0) : $urandom_range(30, 0));
      repeat (200) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, prefetch FIFO entries and maximum outstanding bus requests (legal 2, 4, 8).
REQ-002 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; ports: clk_i input 1, rising-edge clock; rst_i input 1, asynchronous active-high reset.
REQ-004 SHALL have port fetch_en_i, input, 1 bit: enables issuing new bus requests.
REQ-005 SHALL have port instr_req_o, output, 1 bit: bus request.
REQ-006 SHALL have port instr_addr_o, output, 32 bits: word-aligned fetch address.
REQ-007 SHALL have port instr_gnt_i, input, 1 bit: request accepted.
REQ-008 SHALL have port instr_rvalid_i, input, 1 bit: response data valid.
REQ-009 SHALL have port instr_rdata_i, input, 32 bits: response data.
REQ-010 SHALL have port instr_err_i, input, 1 bit: response bus error.
REQ-011 SHALL have port redirect_i, input, 1 bit: taken branch/jump/trap from EX.
REQ-012 SHALL have port redirect_pc_i, input, 32 bits: new fetch target.
REQ-013 SHALL have port instr_valid_o, output, 1 bit: instr_o/pc_o valid to decode.
REQ-014 SHALL have port instr_ready_i, input, 1 bit: decode accepts (not stalled).
REQ-015 SHALL have port instr_o, output, 32 bits: instruction word.
REQ-016 SHALL have port pc_o, output, 32 bits: address of instr_o.
REQ-017 SHALL have port fetch_err_o, output, 1 bit: instruction carries a bus error.

Function
REQ-018 SHALL assert instr_req_o when fetch_en_i=1, redirect_i=0, state=RUN and fifo_count+outstanding < DEPTH.
REQ-019 SHALL hold instr_addr_o stable while instr_req_o=1 and instr_gnt_i=0; instr_gnt_i SHALL be ignored while instr_req_o=0.
REQ-020 SHALL, on req&gnt, increment outstanding and advance fetch address by 4 (32-bit wrap, no saturation).
REQ-021 SHALL, on instr_rvalid_i with discard_cnt=0, push {rdata, pc, err} into FIFO and decrement outstanding; responses return in order, pc tracked by a separate response-address counter.
REQ-022 SHALL, on instr_rvalid_i with discard_cnt>0, drop the response and decrement discard_cnt and outstanding.
REQ-023 SHALL drive instr_valid_o = FIFO non-empty, instr_o/pc_o/fetch_err_o from FIFO head; pop on instr_valid_o&instr_ready_i.
REQ-024 SHALL, on redirect_i, in the same cycle: deassert instr_req_o, clear FIFO, load discard_cnt with outstanding minus any response arriving that cycle, set fetch address to {redirect_pc_i[31:2],2'b00}.
REQ-025 SHALL give redirect priority over a same-cycle pop, push or grant.
REQ-026 SHALL, minimum latency: redirect cycle N -> instr_req_o at N+1 -> (gnt N+1, rvalid N+2) -> instr_valid_o at N+3; FIFO output is registered, no rvalid bypass.
REQ-027 SHALL use states IDLE (after reset until fetch_en_i first high), RUN, HALT_ERR; IDLE->RUN on fetch_en_i; RUN->HALT_ERR on an error entry pushed (macro on); HALT_ERR->RUN on redirect_i.
REQ-028 SHALL never overflow the FIFO: credit rule of REQ-018 guarantees space for every outstanding response.
REQ-029 SHALL, when fetch_en_i drops, stop new requests but still accept outstanding responses.

Reset
REQ-030 SHALL on rst_i set: instr_req_o=0, instr_addr_o=BOOT_ADDR, instr_valid_o=0, instr_o=0, pc_o=0, fetch_err_o=0, FIFO empty, outstanding=0, discard_cnt=0, state=IDLE.
REQ-031 SHALL, on reset mid-transaction, discard all outstanding responses; the bus is reset together with the core.

Configuration
REQ-032 SHALL, with FETCH_BUS_ERR_EN defined, store instr_err_i per entry, drive fetch_err_o from head, and enter HALT_ERR after pushing an error entry.
REQ-033 SHALL, without FETCH_BUS_ERR_EN, ignore instr_err_i, tie fetch_err_o=0, and never enter HALT_ERR.

Structure
REQ-034 SHALL define fetch_entry_t {instr, pc, err} and fetch_state_e {IDLE, RUN, HALT_ERR} in the shared pkg.
REQ-035 SHALL implement the FIFO as sub-module fetch_fifo (DEPTH entries, push/pop/flush, count output).

Verification
REQ-036 SHALL cover reset then fetch_en_i=1, gnt and rvalid always 1 -> addresses 0x0, 0x4, 0x8; instr_valid_o first high on cycle 3.
REQ-037 SHALL cover instr_ready_i=0 for 10 cycles -> at most DEPTH=2 grants, instr_req_o low, no lost or duplicated instruction.
REQ-038 SHALL cover redirect_i with 2 outstanding, redirect_pc_i=0x100 -> both stale responses dropped, next pc_o=0x100.
REQ-039 SHALL cover redirect_pc_i=0x203 -> instr_addr_o=0x200.
REQ-040 SHALL cover, with FETCH_BUS_ERR_EN, instr_err_i=1 on pc 0x8 -> fetch_err_o=1 with pc_o=0x8, no further requests until redirect_i.
REQ-041 SHALL cover redirect_i coincident with rvalid and pop -> FIFO empty next cycle and discard_cnt=outstanding-1.
